// File: rtl/key_event.sv
// key_event: classifies a debounced key level into short, long and
// auto-repeat event pulses, plus a held-status level.
module key_event #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic clk_db,
    input  logic rst_n,
    input  logic en,
    input  logic key_level,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        LOCK  = 2'd0,
        IDLE  = 2'd1,
        PRESS = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Press classifier: state, hold counter and all registered outputs.
    // Pulses default low every cycle so each one lasts exactly one cycle.
    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOCK;
            cnt          <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            if (!en) begin
                // A key held while disabled must be released before it counts.
                state <= key_level ? LOCK : IDLE;
                cnt   <= '0;
                held  <= 1'b0;
            end else begin
                unique case (state)
                    LOCK: begin
                        cnt  <= '0;
                        held <= 1'b0;
                        if (!key_level) begin
                            state <= IDLE;
                        end
                    end
                    IDLE: begin
                        if (key_level) begin
                            state <= PRESS;
                            cnt   <= CNT_ONE;
                            held  <= 1'b1;
                        end else begin
                            cnt  <= '0;
                            held <= 1'b0;
                        end
                    end
                    PRESS: begin
                        if (!key_level) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            held        <= 1'b0;
                            short_pulse <= 1'b1;
                        end else if (cnt == LONG_LAST) begin
                            state      <= HOLD;
                            cnt        <= '0;
                            long_pulse <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HOLD: begin
                        if (!key_level) begin
                            state <= IDLE;
                            cnt   <= '0;
                            held  <= 1'b0;
                        end else if (cnt == REP_LAST) begin
                            cnt          <= '0;
                            repeat_pulse <= REPEAT_EN;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= LOCK;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: randomized and directed stimulus against a run-length
// reference model; expected outputs are queued and checked by a monitor.
module tb_key_event;

    localparam int LONG = 100;
    localparam int REP  = 20;

    logic clk_db = 1'b0;
    logic rst_n;
    logic en;
    logic key_level;
    logic s0, l0, r0, h0;
    logic s1, l1, r1, h1;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    bit lk[2];
    int run[2];

    key_event #(
        .LONG_TICKS(LONG), .REPEAT_TICKS(REP),
        .REPEAT_EN(1'b1), .CNT_W(8)
    ) dut_rep (
        .clk_db(clk_db), .rst_n(rst_n), .en(en),
        .key_level(key_level),
        .short_pulse(s0), .long_pulse(l0),
        .repeat_pulse(r0), .held(h0)
    );

    key_event #(
        .LONG_TICKS(LONG), .REPEAT_TICKS(REP),
        .REPEAT_EN(1'b0), .CNT_W(8)
    ) dut_norep (
        .clk_db(clk_db), .rst_n(rst_n), .en(en),
        .key_level(key_level),
        .short_pulse(s1), .long_pulse(l1),
        .repeat_pulse(r1), .held(h1)
    );

    always #5 clk_db = ~clk_db;

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (short,long,rep,held) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: counts consecutive high samples of the current press.
    function automatic logic [3:0] step(input int i, input bit rep_en);
        logic sh, lo, rp, hd;
        sh = 0; lo = 0; rp = 0; hd = 0;
        if (!rst_n) begin
            lk[i]  = 1;
            run[i] = 0;
        end else if (!en) begin
            lk[i]  = key_level;
            run[i] = 0;
        end else if (lk[i]) begin
            if (!key_level) lk[i] = 0;
        end else if (key_level) begin
            run[i]++;
            hd = 1;
            lo = (run[i] == LONG);
            rp = rep_en && run[i] > LONG && ((run[i] - LONG) % REP == 0);
        end else begin
            sh = (run[i] > 0 && run[i] < LONG);
            run[i] = 0;
        end
        return {sh, lo, rp, hd};
    endfunction

    // Model: one expected entry per clock edge.
    initial begin
        forever begin
            @(posedge clk_db);
            exp_q.push_back({step(0, 1'b1), step(1, 1'b0)});
        end
    end

    // Monitor: compares DUT outputs against the oldest expected entry.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_db);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rep_en1", {s0, l0, r0, h0}, e[7:4]);
                check("rep_en0", {s1, l1, r1, h1}, e[3:0]);
                total++;
                if (!$onehot0({s0, l0, r0}) || !$onehot0({s1, l1, r1})) begin
                    bad++;
                    $display("FAIL mutex: got %b/%b expected at most one pulse",
                             {s0, l0, r0}, {s1, l1, r1});
                end
            end
        end
    end

    task automatic drive(input logic k, input logic e, input int n);
        repeat (n) begin
            @(negedge clk_db);
            key_level = k;
            en        = e;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_db);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst0", {s0, l0, r0, h0}, 4'b0000);
        check("async_rst1", {s1, l1, r1, h1}, 4'b0000);
        repeat (3) @(negedge clk_db);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int len, gap, drop, sel;
        rst_n     = 1'b0;
        en        = 1'b1;
        key_level = 1'b0;
        #3;
        check("por0", {s0, l0, r0, h0}, 4'b0000);
        check("por1", {s1, l1, r1, h1}, 4'b0000);
        repeat (2) @(negedge clk_db);
        #2 rst_n = 1'b1;
        drive(0, 1, 3);

        // short press
        drive(1, 1, 5);
        drive(0, 1, 4);
        // long press with repeats
        drive(1, 1, 145);
        drive(0, 1, 4);
        // threshold boundary
        drive(1, 1, 99);
        drive(0, 1, 3);
        drive(1, 1, 100);
        drive(0, 1, 3);
        // long hold, repeat disabled instance
        drive(1, 1, 200);
        drive(0, 1, 3);
        // back-to-back presses
        drive(1, 1, 3);
        drive(0, 1, 1);
        drive(1, 1, 2);
        drive(0, 1, 3);
        // enable lockout mid-press
        drive(1, 1, 50);
        drive(1, 0, 5);
        drive(1, 1, 150);
        drive(0, 1, 3);
        drive(1, 1, 3);
        drive(0, 1, 3);
        // reset mid-hold with key still high
        drive(1, 1, 120);
        do_reset();
        drive(1, 1, 300);
        drive(0, 1, 2);
        drive(1, 1, 4);
        drive(0, 1, 3);

        // randomized segments
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       len = $urandom_range(1, 4);
                1:       len = $urandom_range(97, 103);
                2:       len = $urandom_range(115, 145);
                default: len = $urandom_range(1, 160);
            endcase
            drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -5;
            for (int c = 0; c < len; c++) begin
                @(negedge clk_db);
                key_level = 1'b1;
                en = (c == drop || c == drop + 1) ? 1'b0 : 1'b1;
            end
            gap = $urandom_range(1, 4);
            drive(0, 1, gap);
            if ($urandom_range(0, 15) == 0) begin
                do_reset();
            end
        end

        drive(0, 1, 4);
        repeat (2) @(posedge clk_db);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
